// File: rtl/pentary_pkg.sv
// Shared definitions for the Pentary core: word and register-address types.
// A word is 16 pentary digits of 3 bits each, treated as opaque data here.
package pentary_pkg;

  localparam int DATA_WIDTH     = 48;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;

  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Handles address decode, R0 masking and the same-cycle write bypass.
module regfile_read_port
  import pentary_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          read_addr,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic                           write_enable,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic [DATA_WIDTH-1:0]          read_data
);

  logic [DATA_WIDTH-1:0] entry [NUM_REGS];
  logic                  bypass_hit;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
    assign entry[i] = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Bypass is suppressed during reset so reads show the (cleared) storage.
  assign bypass_hit = !reset && write_enable && (write_addr == read_addr);

  always_comb begin
    read_data = entry[read_addr];
    if (read_addr == ADDR_WIDTH'(REG_ZERO)) begin
      read_data = '0;
    end else if (bypass_hit) begin
      read_data = write_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 48-bit register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero, same-cycle write forwarded to readers.
module register_file
  import pentary_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  output logic [DATA_WIDTH-1:0] read_data1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable
);

  // Write strobe: write_enable is a single-cycle qualifier sampled at the
  // rising edge; there is no back-pressure, every strobed write is accepted.
  logic [DATA_WIDTH-1:0]          regs [1:NUM_REGS-1];
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;

  assign regs_flat[0 +: DATA_WIDTH] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (write_enable && (write_addr == ADDR_WIDTH'(i))) begin
        regs[i] <= write_data;
      end
    end
    assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_read_port1 (
    .reset        (reset),
    .read_addr    (read_addr1),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .regs_flat    (regs_flat),
    .read_data    (read_data1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_read_port2 (
    .reset        (reset),
    .read_addr    (read_addr2),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .regs_flat    (regs_flat),
    .read_data    (read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with hand-computed expected values.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  read_addr1;
  logic [47:0] read_data1;
  logic [4:0]  read_addr2;
  logic [47:0] read_data2;
  logic [4:0]  write_addr;
  logic [47:0] write_data;
  logic        write_enable;

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];

  register_file dut (
    .clk          (clk),
    .reset        (reset),
    .read_addr1   (read_addr1),
    .read_data1   (read_data1),
    .read_addr2   (read_addr2),
    .read_data2   (read_data2),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [47:0] data);
    write_enable = 1'b1;
    write_addr   = addr;
    write_data   = data;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic read_check1(input string tag, input logic [4:0] addr, input logic [47:0] exp);
    read_addr1 = addr;
    #1;
    check(tag, read_data1, exp);
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = '0;
    read_addr1 = '0; read_addr2 = '0;
    tick();
    tick();
    reset = 1'b0;

    // fill R1..R31 with i*0x1111 and read back through the scoreboard
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 48'(i * 32'h1111));
      exp_q.push_back(48'(i * 32'h1111));
    end
    for (int i = 1; i < 32; i++) begin
      read_check1("fill_readback", 5'(i), exp_q.pop_front());
    end

    // reset clears everything
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_check1("reset_clear", 5'(i), 48'h0);
    end

    // write/read with idle edges
    write_reg(5'd1, 48'hAAAAAAAAAAAA);
    tick();
    write_reg(5'd31, 48'h555555555555);
    tick();
    read_check1("wr_r1", 5'd1, 48'hAAAAAAAAAAAA);
    read_check1("wr_r31", 5'd31, 48'h555555555555);

    // R0 hardwired, no bypass to R0
    write_reg(5'd0, 48'hFFFFFFFFFFFF);
    read_check1("r0_read", 5'd0, 48'h0);
    write_enable = 1'b1; write_addr = 5'd0; write_data = 48'hFFFFFFFFFFFF;
    read_addr2 = 5'd0;
    read_check1("r0_nobypass1", 5'd0, 48'h0);
    check("r0_nobypass2", read_data2, 48'h0);
    write_enable = 1'b0;

    // dual port same cycle
    write_reg(5'd2, 48'h222222222222);
    write_reg(5'd3, 48'h333333333333);
    read_addr1 = 5'd2; read_addr2 = 5'd3;
    #1;
    check("dual_p1", read_data1, 48'h222222222222);
    check("dual_p2", read_data2, 48'h333333333333);

    // bypass on both ports, before and after the edge
    write_reg(5'd4, 48'h123456789ABC);
    write_enable = 1'b1; write_addr = 5'd4; write_data = 48'h444444444444;
    read_addr2 = 5'd4;
    read_check1("bypass_pre", 5'd4, 48'h444444444444);
    check("bypass_pre_p2", read_data2, 48'h444444444444);
    tick();
    check("bypass_post", read_data1, 48'h444444444444);
    write_enable = 1'b0;
    #1;
    check("bypass_stored", read_data1, 48'h444444444444);

    // bypass suppressed under reset, reset wins over the write
    reset = 1'b1; write_enable = 1'b1; write_addr = 5'd4; write_data = 48'h999999999999;
    #1;
    check("rst_nobypass_pre", read_data1, 48'h444444444444);
    tick();
    check("rst_nobypass_post", read_data1, 48'h0);
    reset = 1'b0; write_enable = 1'b0;
    read_check1("rst_write_lost", 5'd4, 48'h0);

    // back-to-back last write wins
    write_reg(5'd5, 48'h000000000001);
    write_reg(5'd5, 48'h000000000002);
    read_check1("last_wins", 5'd5, 48'h000000000002);

    // all registers, byte i replicated, back-to-back
    write_enable = 1'b1;
    for (int i = 1; i < 32; i++) begin
      logic [7:0] b;
      b = 8'(i);
      write_addr = 5'(i);
      write_data = {6{b}};
      exp_q.push_back({6{b}});
      tick();
    end
    write_enable = 1'b0;
    for (int i = 1; i < 32; i++) begin
      read_addr2 = 5'(i);
      #1;
      check("all_regs_p2", read_data2, exp_q.pop_front());
    end
    read_check1("all_regs_r31", 5'd31, 48'h1F1F1F1F1F1F);
    read_check1("all_regs_r0", 5'd0, 48'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
